spi_host_master: RTL and testbench
==================================

SPI_HOST_MASTER -- requirements
Module: spi_host_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period (legal values 1..255).
REQ-002 SHALL have parameter DUMMY_CYCLES, default 8, sclk cycles between address and data on reads (legal values 0..31).
REQ-003 SHALL have port clk  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake, accepted when both are high.
REQ-006 SHALL have ports cmd_opcode in 8, cmd_addr in 24, cmd_len in 16 (data bytes), cmd_read in 1, cmd_quad in 1, cmd_cs_sel in 1 (0=cs0, 1=cs1).
REQ-007 SHALL have ports wr_data in 8, wr_valid in 1, wr_ready out 1: write-data stream, one byte per handshake.
REQ-008 SHALL have ports rd_data out 8, rd_valid out 1: read-data stream with no backpressure.
REQ-009 SHALL have port done out 1: one-cycle pulse when a transaction ends.
REQ-010 SHALL have ports spi_cs0 out 1, spi_cs1 out 1 (active low), spi_sclk out 1.
REQ-011 SHALL have ports io_out out 4, io_oe out 4, io_in in 4; bit0=mosi_d0, bit1=miso_d1, bit2=d2, bit3=d3.

Function
REQ-012 SHALL use SPI mode 0: sclk idles low; master drives on the falling edge; both sides sample on the rising edge.
REQ-013 SHALL toggle sclk only after CLK_DIV clk cycles in a phase; one sclk period = 2*CLK_DIV clk cycles.
REQ-014 SHALL raise cmd_ready only in IDLE; on acceptance it SHALL latch all cmd_* fields and enter CS_SETUP.
REQ-015 SHALL use states IDLE -> CS_SETUP -> OPCODE -> ADDR -> [DUMMY if cmd_read] -> [DATA if cmd_len!=0] -> CS_HOLD -> IDLE.
REQ-016 CS_SETUP SHALL drive the selected CS low and hold sclk low for CLK_DIV cycles, with the first data bit already on the lines.
REQ-017 OPCODE SHALL shift 8 bits MSB first on d0 only, using 8 sclk; io_oe=4'b0001.
REQ-018 ADDR SHALL shift 24 bits MSB first: single lane (24 sclk) if cmd_quad=0; quad (6 sclk, d3=MSB of each nibble) if cmd_quad=1; io_oe=4'b1111 in quad.
REQ-019 DUMMY SHALL run DUMMY_CYCLES sclk with io_oe=0; it SHALL be skipped when DUMMY_CYCLES=0.
REQ-020 A DATA write SHALL send bytes MSB first, single lane (8 sclk/byte) or quad (2 sclk/byte, high nibble first).
REQ-021 A DATA write SHALL take each byte via wr_ready&&wr_valid before that byte's first bit is driven; wr_ready SHALL be high only at that point.
REQ-022 On write underflow (wr_valid low at a byte boundary), sclk SHALL stay low with CS still asserted until wr_valid rises; no bits are lost or duplicated.
REQ-023 A DATA read SHALL sample io_in[1] (single) or io_in[3:0] (quad) on the rising edges, with io_oe=0.
REQ-024 rd_valid SHALL pulse one cycle per completed byte, with rd_data valid in that cycle; it SHALL fire within 2 clk cycles of the byte's last rising edge.
REQ-025 CS_HOLD SHALL keep CS low and sclk low for CLK_DIV cycles after the last falling edge, then deassert CS.
REQ-026 done SHALL pulse on the same cycle CS deasserts; the state SHALL return to IDLE and cmd_ready SHALL rise on the next cycle.
REQ-027 cmd_len SHALL count down; cmd_len=0 SHALL skip DATA entirely; 65535 SHALL be supported without wrap.
REQ-028 Only the CS selected by cmd_cs_sel SHALL ever go low; both CS SHALL never be low together.
REQ-029 io_out SHALL be 0 wherever io_oe is 0.

Reset
REQ-030 In the cycle after reset is asserted, the block SHALL be in IDLE with spi_cs0=spi_cs1=1, spi_sclk=0, io_oe=0, io_out=0, cmd_ready=1, wr_ready=0, rd_valid=0, done=0, rd_data=0.
REQ-031 Reset during a transaction SHALL abort it immediately: CS high, no done pulse, partial byte discarded.

Verification
REQ-032 Write, single lane, CLK_DIV=2, opcode 0x02, addr 0x000100, len 2, data 0xA5,0x3C, cs_sel 0 -> 48 sclk; a slave model captures 02 00 01 00 A5 3C; spi_cs1 stays high; one done.
REQ-033 Quad read, opcode 0x6B, addr 0x123456, len 3, DUMMY_CYCLES=8, slave returns 0x11,0x22,0xEF -> 8+6+8+6 sclk; exactly three rd_valid pulses carrying 11,22,EF; io_oe=0 from DUMMY onward.
REQ-034 Quad write, len 4, wr_valid held low for 20 cycles before byte 3 -> sclk frozen low with CS asserted during the gap; slave receives all 4 bytes in order.
REQ-035 cmd_len=0, cmd_read=1, DUMMY_CYCLES=0, CLK_DIV=1 -> 32 sclk only; done pulses; no rd_valid.
REQ-036 reset asserted mid-ADDR -> next cycle CS high, sclk 0, cmd_ready 1, no done; the following command completes correctly.

Source files
------------

// File: rtl/spi_host_master.sv
// Mode-0 SPI flash-style host: opcode, address, optional dummy and data phases on one or four lanes.
// Commands are taken only when idle; write bytes are pulled one per handshake; read bytes are pushed without backpressure.
module spi_host_master #(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [23:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        cmd_read,
  input  logic        cmd_quad,
  input  logic        cmd_cs_sel,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        spi_cs0,
  output logic        spi_cs1,
  output logic        spi_sclk,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_in
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] OPCODE   = 3'd2;
  localparam logic [2:0] ADDR     = 3'd3;
  localparam logic [2:0] DUMMY    = 3'd4;
  localparam logic [2:0] DATA     = 3'd5;
  localparam logic [2:0] CS_HOLD  = 3'd6;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic        read_q, read_d;
  logic        quad_q, quad_d;
  logic        lane4_q, lane4_d;
  logic        need_q, need_d;
  logic [1:0]  cs_q, cs_d;
  logic [3:0]  oe_q, oe_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;

  logic        phase_end;
  logic [7:0]  rx_next;

  assign phase_end = (div_q == DIV_LAST);
  assign cmd_ready = (state_q == IDLE) && !done_q;
  assign wr_ready  = need_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign spi_cs0   = cs_q[0];
  assign spi_cs1   = cs_q[1];
  assign spi_sclk  = sclk_q;
  assign io_oe     = oe_q;
  assign io_out    = oe_q & (lane4_q ? sh_q[23:20] : {3'b000, sh_q[23]});

  always_comb begin
    state_d    = state_q;
    div_d      = phase_end ? 8'd0 : div_q + 8'd1;
    sclk_d     = sclk_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    read_d     = read_q;
    quad_d     = quad_q;
    lane4_d    = lane4_q;
    need_d     = need_q;
    cs_d       = cs_q;
    oe_d       = oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    rx_next    = lane4_q ? {rx_q[3:0], io_in} : {rx_q[6:0], io_in[1]};

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (cmd_valid && cmd_ready) begin
          len_d   = cmd_len;
          addr_d  = cmd_addr;
          read_d  = cmd_read;
          quad_d  = cmd_quad;
          lane4_d = 1'b0;
          sh_d    = {cmd_opcode, 16'h0000};
          oe_d    = 4'b0001;
          cs_d    = cmd_cs_sel ? 2'b01 : 2'b10;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          cnt_d   = 5'd7;
          state_d = OPCODE;
        end
      end
      OPCODE, ADDR, DUMMY, DATA: begin
        if (need_q) begin
          // Write underflow: sclk parks low until the next byte arrives.
          div_d = '0;
          if (wr_valid) begin
            sh_d   = {wr_data, 16'h0000};
            need_d = 1'b0;
          end
        end else if (phase_end) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == DATA && read_q) begin
              rx_d = rx_next;
              if (cnt_q == '0) begin
                rd_data_d  = rx_next;
                rd_valid_d = 1'b1;
              end
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 5'd1;
            sh_d  = lane4_q ? {sh_q[19:0], 4'h0} : {sh_q[22:0], 1'b0};
          end else begin
            case (state_q)
              OPCODE: begin
                state_d = ADDR;
                sh_d    = addr_q;
                lane4_d = quad_q;
                oe_d    = quad_q ? 4'b1111 : 4'b0001;
                cnt_d   = quad_q ? 5'd5 : 5'd23;
              end
              DATA: begin
                len_d = len_q - 16'd1;
                cnt_d = quad_q ? 5'd1 : 5'd7;
                if (len_q == 16'd1) begin
                  state_d = CS_HOLD;
                  oe_d    = 4'b0000;
                end else if (!read_q) begin
                  need_d = 1'b1;
                  sh_d   = '0;
                end
              end
              default: begin
                if (state_q == ADDR && read_q && DUMMY_CYCLES != 0) begin
                  state_d = DUMMY;
                  oe_d    = 4'b0000;
                  cnt_d   = DUMMY_LAST;
                end else if (len_q == 16'd0) begin
                  state_d = CS_HOLD;
                  oe_d    = 4'b0000;
                end else begin
                  state_d = DATA;
                  lane4_d = quad_q;
                  cnt_d   = quad_q ? 5'd1 : 5'd7;
                  sh_d    = '0;
                  oe_d    = read_q ? 4'b0000 : (quad_q ? 4'b1111 : 4'b0001);
                  need_d  = !read_q;
                end
              end
            endcase
          end
        end
      end
      CS_HOLD: begin
        if (phase_end) begin
          cs_d    = 2'b11;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      read_q     <= 1'b0;
      quad_q     <= 1'b0;
      lane4_q    <= 1'b0;
      need_q     <= 1'b0;
      cs_q       <= 2'b11;
      oe_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      read_q     <= read_d;
      quad_q     <= quad_d;
      lane4_q    <= lane4_d;
      need_q     <= need_d;
      cs_q       <= cs_d;
      oe_q       <= oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_host_master.sv
// Scoreboard bench for spi_host_master: a slave model captures shifted bytes and feeds read nibbles,
// while independent monitors pop expected bytes, sclk counts and read data.
`timescale 1ns/1ps
module tb_spi_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;
  logic [7:0]  cmd_opcode = '0;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        cmd_read = 1'b0, cmd_quad = 1'b0, cmd_cs_sel = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_valid_b = 1'b0;
  logic [3:0]  io_in_a = '0, io_in_b = '0;

  logic cmd_ready_a, wr_ready_a, rd_valid_a, done_a, cs0_a, cs1_a, sclk_a;
  logic [7:0] rd_data_a;
  logic [3:0] io_out_a, io_oe_a;
  logic cmd_ready_b, wr_ready_b, rd_valid_b, done_b, cs0_b, cs1_b, sclk_b;
  logic [7:0] rd_data_b;
  logic [3:0] io_out_b, io_oe_b;

  spi_host_master #(.CLK_DIV(2), .DUMMY_CYCLES(8)) u_dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_read(cmd_read),
    .cmd_quad(cmd_quad), .cmd_cs_sel(cmd_cs_sel), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .done(done_a),
    .spi_cs0(cs0_a), .spi_cs1(cs1_a), .spi_sclk(sclk_a), .io_out(io_out_a), .io_oe(io_oe_a),
    .io_in(io_in_a));

  spi_host_master #(.CLK_DIV(1), .DUMMY_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_read(cmd_read),
    .cmd_quad(cmd_quad), .cmd_cs_sel(cmd_cs_sel), .wr_data(wr_data), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .done(done_b),
    .spi_cs0(cs0_b), .spi_cs1(cs1_b), .spi_sclk(sclk_b), .io_out(io_out_b), .io_oe(io_oe_b),
    .io_in(io_in_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_slave[$];
  logic [7:0] exp_rd[$];
  int         exp_sclk[$];
  logic [7:0] wr_bytes[$];
  logic [7:0] slv_rd [0:3];

  // Transaction shape the slave model decodes against.
  logic tb_quad = 1'b0, tb_read = 1'b0, tb_cs_sel = 1'b0;
  int   tb_alen = 24, tb_dlen = 0, rd_n = 0;
  int   gap_idx = -1, gap_len = 0;
  logic in_gap = 1'b0;

  int   rise_a = 0, sbits = 0, oe_viol = 0, cs_viol = 0, gap_viol = 0, stall_cyc = 0;
  int   done_cnt_a = 0, rd_cnt_a = 0;
  int   rise_b = 0, done_cnt_b = 0, rdv_b = 0;
  logic [7:0] sacc = '0;
  logic chk_ready_next = 1'b0;
  logic cs_n_a, cs_n_b;
  assign cs_n_a = cs0_a & cs1_a;
  assign cs_n_b = cs0_b & cs1_b;

  always @(negedge cs_n_a) begin
    rise_a  = 0;
    sbits   = 0;
    sacc    = '0;
    io_in_a = 4'h0;
  end

  always @(posedge sclk_a) begin : slave_capture
    logic lanes4;
    logic capture;
    if (!cs_n_a) begin
      capture = 1'b1;
      if (rise_a < 8) lanes4 = 1'b0;
      else if (rise_a < 8 + tb_alen) lanes4 = tb_quad;
      else begin
        lanes4 = tb_quad;
        if (tb_read) begin
          capture = 1'b0;
          if (io_oe_a !== 4'h0) oe_viol++;
        end
      end
      if (capture) begin
        if (lanes4) begin sacc = {sacc[3:0], io_out_a}; sbits += 4; end
        else begin sacc = {sacc[6:0], io_out_a[0]}; sbits += 1; end
        if (sbits == 8) begin
          sbits = 0;
          if (exp_slave.size() == 0) begin
            checks++; errors++;
            $display("FAIL slave_byte: got 0x%0h, expected no byte", sacc);
          end else check("slave_byte", {24'h0, sacc}, {24'h0, exp_slave.pop_front()});
        end
      end
      rise_a++;
    end
  end

  always @(negedge sclk_a) begin : slave_drive
    int k;
    k = rise_a - (8 + tb_alen + tb_dlen);
    if (!cs_n_a && tb_read && k >= 0 && k < 2 * rd_n)
      io_in_a = (k % 2 == 0) ? slv_rd[k/2][7:4] : slv_rd[k/2][3:0];
    else
      io_in_a = 4'h0;
  end

  always @(negedge clk) begin
    if (!cs0_a && !cs1_a) cs_viol++;
    if (!tb_cs_sel && cs1_a === 1'b0) cs_viol++;
    if (tb_cs_sel && cs0_a === 1'b0) cs_viol++;
    if (in_gap && wr_ready_a) begin
      stall_cyc++;
      if (sclk_a !== 1'b0 || cs_n_a !== 1'b0) gap_viol++;
    end
    if (chk_ready_next) begin
      check("ready_after_done", cmd_ready_a, 1);
      chk_ready_next = 1'b0;
    end
    if (done_a === 1'b1) begin
      done_cnt_a++;
      check("cs_high_at_done", {cs0_a, cs1_a}, 2'b11);
      check("ready_low_at_done", cmd_ready_a, 0);
      if (exp_sclk.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done, expected none");
      end else check("sclk_count", rise_a, exp_sclk.pop_front());
      chk_ready_next = 1'b1;
    end
    if (rd_valid_a === 1'b1) begin
      rd_cnt_a++;
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd: got 0x%0h, expected none", rd_data_a);
      end else check("rd_data", rd_data_a, exp_rd.pop_front());
    end
    if (done_b === 1'b1) done_cnt_b++;
    if (rd_valid_b === 1'b1) rdv_b++;
  end

  always @(negedge cs_n_b) rise_b = 0;
  always @(posedge sclk_b) if (!cs_n_b) rise_b++;

  task automatic issue_a(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] len,
                         input logic rd, input logic q, input logic cs);
    int n;
    tb_quad = q; tb_read = rd; tb_cs_sel = cs;
    tb_alen = q ? 6 : 24;
    tb_dlen = rd ? 8 : 0;
    cmd_opcode = op; cmd_addr = addr; cmd_len = len;
    cmd_read = rd; cmd_quad = q; cmd_cs_sel = cs;
    cmd_valid_a = 1'b1;
    n = 0;
    while (!cmd_ready_a && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin checks++; errors++; $display("FAIL cmd_accept_timeout: got no cmd_ready, expected 1"); end
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic drive_wr();
    int n;
    int idx;
    idx = 0;
    while (wr_bytes.size() != 0) begin
      if (idx == gap_idx) begin
        in_gap = 1'b1;
        repeat (gap_len) @(negedge clk);
        in_gap = 1'b0;
      end
      wr_data = wr_bytes.pop_front();
      wr_valid = 1'b1;
      n = 0;
      while (!wr_ready_a && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin checks++; errors++; $display("FAIL wr_timeout: got no wr_ready, expected 1"); end
      @(negedge clk);
      wr_valid = 1'b0;
      idx++;
    end
  endtask

  task automatic wait_done_a(input int target);
    int n;
    n = 0;
    while (done_cnt_a < target && n < 3000) begin @(negedge clk); n++; end
    check("done_count_a", done_cnt_a, target);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    @(negedge clk);
    check("rst_cs0", cs0_a, 1);
    check("rst_cs1", cs1_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_io_oe", io_oe_a, 0);
    check("rst_io_out", io_out_a, 0);
    check("rst_cmd_ready", cmd_ready_a, 1);
    check("rst_wr_ready", wr_ready_a, 0);
    check("rst_rd_valid", rd_valid_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_data", rd_data_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single-lane write to cs0.
    exp_slave = '{8'h02, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h3C};
    exp_sclk.push_back(48);
    wr_bytes = '{8'hA5, 8'h3C};
    fork
      issue_a(8'h02, 24'h000100, 16'd2, 1'b0, 1'b0, 1'b0);
      drive_wr();
    join
    wait_done_a(1);

    // Quad read with 8 dummy clocks.
    slv_rd[0] = 8'h11; slv_rd[1] = 8'h22; slv_rd[2] = 8'hEF; rd_n = 3;
    exp_slave = '{8'h6B, 8'h12, 8'h34, 8'h56};
    exp_rd = '{8'h11, 8'h22, 8'hEF};
    exp_sclk.push_back(28);
    issue_a(8'h6B, 24'h123456, 16'd3, 1'b1, 1'b1, 1'b0);
    wait_done_a(2);
    check("rd_valid_pulses", rd_cnt_a, 3);
    check("quad_read_oe_zero", oe_viol, 0);
    rd_n = 0;

    // Quad write with a 20-cycle write-data gap before byte 3.
    exp_slave = '{8'h32, 8'h00, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_sclk.push_back(22);
    wr_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    gap_idx = 2; gap_len = 20;
    fork
      issue_a(8'h32, 24'h000200, 16'd4, 1'b0, 1'b1, 1'b0);
      drive_wr();
    join
    wait_done_a(3);
    gap_idx = -1;
    check("gap_sclk_frozen", gap_viol, 0);
    check("gap_stalled", stall_cyc > 5, 1);

    // Zero-length read on the fast, no-dummy instance.
    cmd_opcode = 8'h03; cmd_addr = 24'hABCDEF; cmd_len = 16'd0;
    cmd_read = 1'b1; cmd_quad = 1'b0; cmd_cs_sel = 1'b0;
    cmd_valid_b = 1'b1;
    n = 0;
    while (!cmd_ready_b && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid_b = 1'b0;
    n = 0;
    while (done_cnt_b < 1 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("b_done_count", done_cnt_b, 1);
    check("b_sclk_count", rise_b, 32);
    check("b_no_rd_valid", rdv_b, 0);
    check("b_cs_idle", {cs0_b, cs1_b}, 2'b11);

    // Reset in the middle of the address phase.
    exp_slave = '{8'h02};
    cmd_opcode = 8'h02; cmd_addr = 24'h00ABCD; cmd_len = 16'd1;
    issue_a(8'h02, 24'h00ABCD, 16'd1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (rise_a < 12 && n < 500) begin @(negedge clk); n++; end
    check("reached_addr", rise_a >= 12, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs0", cs0_a, 1);
    check("abort_cs1", cs1_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_cmd_ready", cmd_ready_a, 1);
    check("abort_done", done_a, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt_a, 3);

    // Post-abort command on cs1.
    exp_slave = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h5A};
    exp_sclk.push_back(40);
    wr_bytes = '{8'h5A};
    fork
      issue_a(8'h02, 24'h000010, 16'd1, 1'b0, 1'b0, 1'b1);
      drive_wr();
    join
    wait_done_a(4);

    check("slave_queue_empty", exp_slave.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("sclk_queue_empty", exp_sclk.size(), 0);
    check("cs_select_rule", cs_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
